bin_bcd_barrido: RTL and testbench

BIN_BCD_BARRIDO -- requirements
Module: bin_bcd_barrido

---
 rtl/booth_pkg.sv | 14 +
 rtl/bin_a_bcd.sv | 36 +++
 rtl/bin_bcd_barrido.sv | 79 +++++++
 tb/tb_bin_bcd_barrido.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the Booth product display path.
package booth_pkg;
  typedef enum logic {ESPERA, CONVIERTE} estado_t;
  localparam int ANCHO_PRODUCTO = 16;
  localparam int N_DIGITOS = 5;
  localparam int N_POSICIONES = 6;
  localparam logic [6:0] SEG_MENOS = 7'b1111110;
  function automatic logic [4*N_DIGITOS-1:0] ajusta(input logic [4*N_DIGITOS-1:0] b);
    logic [4*N_DIGITOS-1:0] r;
    for (int i = 0; i < N_DIGITOS; i++)
      r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/bin_a_bcd.sv
// bin_a_bcd: iterative double-dabble, 17-bit magnitude to 5 BCD digits in 16 steps.
module bin_a_bcd
  import booth_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inicio,
  input  logic [ANCHO_PRODUCTO:0]    magnitud,
  output logic [4*N_DIGITOS-1:0]     bcd,
  output logic                       fin
);
  logic [ANCHO_PRODUCTO-1:0] bin;
  logic [3:0] cuenta;
  logic activo;
  // The top magnitude bit is loaded pre-shifted; early shifts never need an adjust.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bcd <= '0;
      bin <= '0;
      cuenta <= '0;
      activo <= 1'b0;
      fin <= 1'b0;
    end else begin
      fin <= activo && cuenta == 4'd15;
      if (inicio) begin
        bcd <= {{(4*N_DIGITOS-1){1'b0}}, magnitud[ANCHO_PRODUCTO]};
        bin <= magnitud[ANCHO_PRODUCTO-1:0];
        cuenta <= '0;
        activo <= 1'b1;
      end else if (activo) begin
        {bcd, bin} <= {ajusta(bcd), bin} << 1;
        cuenta <= cuenta + 4'd1;
        if (cuenta == 4'd15) activo <= 1'b0;
      end
    end
endmodule

// File: rtl/bin_bcd_barrido.sv
// bin_bcd_barrido: converts a signed Booth product to BCD and scans it onto
// a multiplexed 7-segment display with leading-zero blanking and a sign slot.
module bin_bcd_barrido
  import booth_pkg::*;
#(
  parameter int REFRESCO = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ANCHO_PRODUCTO-1:0] producto,
  input  logic                      cargar,
  output logic                      ocupado,
  output logic                      listo,
  output logic [3:0]                digito,
  output logic [7:0]                anodos,
  output logic                      signo
);
  estado_t estado;
  logic armado, inicio, fin, sgn_conv, disp_sgn;
  logic [ANCHO_PRODUCTO:0] magnitud;
  logic [4*N_DIGITOS-1:0] bcd, disp;
  logic [31:0] div;
  logic [2:0] pos;
  logic [N_POSICIONES-1:0] lit;
  assign inicio = armado && estado == ESPERA && cargar;
  assign magnitud = producto[ANCHO_PRODUCTO-1] ? ~{1'b1, producto} + 17'd1 : {1'b0, producto};
  bin_a_bcd u_conv (
    .clk(clk),
    .rst_n(rst_n),
    .inicio(inicio),
    .magnitud(magnitud),
    .bcd(bcd),
    .fin(fin)
  );
  // A digit slot is lit when it or any more significant digit is non-zero.
  always_comb begin
    lit = {disp_sgn, {N_DIGITOS{1'b0}}};
    for (int p = 0; p < N_DIGITOS; p++) lit[p] = p == 0 || |(disp >> (4*p));
  end
  // armado delays the first state change to the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armado <= 1'b0;
      estado <= ESPERA;
      div <= '0;
      pos <= '0;
      disp <= '0;
      disp_sgn <= 1'b0;
      sgn_conv <= 1'b0;
      ocupado <= 1'b0;
      listo <= 1'b0;
      digito <= '0;
      signo <= 1'b0;
      anodos <= 8'b11111110;
    end else begin
      armado <= 1'b1;
      if (armado) begin
        listo <= 1'b0;
        div <= div == 32'(REFRESCO - 1) ? '0 : div + 32'd1;
        if (div == 32'(REFRESCO - 1)) pos <= pos == 3'd5 ? '0 : pos + 3'd1;
        digito <= pos == 3'd5 ? 4'd0 : 4'(disp >> {pos, 2'b00});
        signo <= pos == 3'd5 && disp_sgn;
        anodos <= ~({2'b00, lit} & (8'd1 << pos));
        if (estado == ESPERA) begin
          if (cargar) begin
            estado <= CONVIERTE;
            sgn_conv <= producto[ANCHO_PRODUCTO-1];
            ocupado <= 1'b1;
          end
        end else if (fin) begin
          estado <= ESPERA;
          ocupado <= 1'b0;
          listo <= 1'b1;
          disp <= bcd;
          disp_sgn <= sgn_conv;
        end
      end
    end
endmodule

// File: tb/tb_bin_bcd_barrido.sv
// tb_bin_bcd_barrido: directed checks of conversion timing, scan and blanking.
module tb_bin_bcd_barrido;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [15:0] producto = '0;
  logic cargar = 1'b0;
  logic ocupado, listo, signo;
  logic [3:0] digito;
  logic [7:0] anodos;
  int checks = 0;
  int failures = 0;

  bin_bcd_barrido #(.REFRESCO(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .producto(producto),
    .cargar(cargar),
    .ocupado(ocupado),
    .listo(listo),
    .digito(digito),
    .anodos(anodos),
    .signo(signo)
  );

  always #5 clk = ~clk;

  task automatic comprueba(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input logic [7:0] a);
    for (int q = 0; q < 6; q++) if (a == 8'(~(8'd1 << q))) return q;
    return -1;
  endfunction

  task automatic reset_vals(input string tag);
    comprueba({tag, "_ocupado"}, int'(ocupado), 0);
    comprueba({tag, "_listo"}, int'(listo), 0);
    comprueba({tag, "_digito"}, int'(digito), 0);
    comprueba({tag, "_signo"}, int'(signo), 0);
    comprueba({tag, "_anodos"}, int'(anodos), 8'hFE);
  endtask

  task automatic run_conv(input string tag, input logic [15:0] v, input bit extra, input logic [15:0] v2);
    int oc, lc, nl;
    oc = 0; lc = 0; nl = 0;
    @(negedge clk); producto = v; cargar = 1'b1;
    @(negedge clk); cargar = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) @(negedge clk);
      if (ocupado) oc++;
      if (listo) begin
        nl++;
        if (lc == 0) lc = i;
      end
      if (extra && i == 4) begin producto = v2; cargar = 1'b1; end
      if (extra && i == 5) cargar = 1'b0;
    end
    comprueba({tag, "_ocupado_cycles"}, oc, 17);
    comprueba({tag, "_listo_cycle"}, lc, 18);
    comprueba({tag, "_listo_pulses"}, nl, 1);
  endtask

  task automatic scan_chk(input string tag, input logic [23:0] digs, input logic [5:0] lit, input logic sg);
    int cnt[6];
    int dark, bad_dig, bad_sg, bad_an, p;
    cnt = '{default: 0};
    dark = 0; bad_dig = 0; bad_sg = 0; bad_an = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      p = pos_of(anodos);
      if (anodos == 8'hFF) begin
        dark++;
        if (signo) bad_sg++;
      end else if (p < 0) bad_an++;
      else begin
        cnt[p]++;
        if (digito != digs[4*p +: 4]) bad_dig++;
        if (signo != (p == 5 && sg)) bad_sg++;
      end
    end
    for (int q = 0; q < 6; q++) comprueba($sformatf("%s_pos%0d_cycles", tag, q), cnt[q], lit[q] ? 4 : 0);
    comprueba({tag, "_dark_cycles"}, dark, 24 - 4 * $countones(lit));
    comprueba({tag, "_bad_digits"}, bad_dig, 0);
    comprueba({tag, "_bad_signo"}, bad_sg, 0);
    comprueba({tag, "_bad_anodos"}, bad_an, 0);
  endtask

  initial begin
    int prev, p, bad, wraps, nl, oc;
    #2 rst_n = 1'b0;
    #2 reset_vals("reset_async");
    repeat (3) @(negedge clk);
    reset_vals("reset_held");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_conv("c1234", 16'd1234, 1'b0, 16'd0);
    scan_chk("s1234", 24'h001234, 6'b001111, 1'b0);

    run_conv("cmin", 16'h8000, 1'b0, 16'd0);
    scan_chk("smin", 24'h032768, 6'b111111, 1'b1);
    prev = -1; bad = 0; wraps = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      p = pos_of(anodos);
      if (p < 0) bad++;
      else if (prev >= 0 && p != prev) begin
        if (p != (prev + 1) % 6) bad++;
        if (prev == 5 && p == 0) wraps++;
      end
      prev = p;
    end
    comprueba("wrap_order_errors", bad, 0);
    comprueba("wrap_5_to_0_seen", int'(wraps > 0), 1);

    run_conv("c0", 16'd0, 1'b0, 16'd0);
    scan_chk("s0", 24'h000000, 6'b000001, 1'b0);

    run_conv("c555", 16'd555, 1'b1, 16'd99);
    scan_chk("s555", 24'h000555, 6'b000111, 1'b0);

    @(negedge clk); producto = 16'd777; cargar = 1'b1;
    @(negedge clk); cargar = 1'b0;
    repeat (7) @(negedge clk);
    comprueba("mid_ocupado_before_reset", int'(ocupado), 1);
    rst_n = 1'b0;
    #1 reset_vals("reset_mid");
    @(negedge clk); rst_n = 1'b1;
    nl = 0; oc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (listo) nl++;
      if (ocupado) oc++;
    end
    comprueba("after_reset_listo", nl, 0);
    comprueba("after_reset_ocupado", oc, 0);
    run_conv("c42", 16'd42, 1'b0, 16'd0);
    scan_chk("s42", 24'h000042, 6'b000011, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
